// File: rtl/key_scan_ctrl.sv
// 4x4 active-low key matrix scanner with debounce and single-key encoding.
// Drives the nkpls/bcds/koff/clr key-strobe interface for the display data generator.
module key_scan_ctrl #(
  parameter int          SCAN_DIV = 1000,
  parameter int          DB_SCANS = 4,
  parameter logic [3:0]  CLR_CODE = 4'hE
) (
  input  logic       rst,
  input  logic       clk,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] bcds,
  output logic       nkpls,
  output logic       koff,
  output logic       clr
);

  localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]     DB_MAX   = 4'(DB_SCANS);

  typedef enum logic [1:0] {RES_NONE = 2'd0, RES_KEY = 2'd1, RES_MULTI = 2'd2} res_t;
  typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, GAP = 2'd2} state_t;

  logic [3:0]       row_meta_r, row_sync_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       col_idx_r;
  logic [15:0]      hits_r;
  logic [15:0]      scan_hits_s;
  logic [4:0]       hit_cnt_s;
  logic [3:0]       hit_code_s;
  logic             tc_s;
  res_t             res_type_r, prev_type_r;
  logic [3:0]       res_code_r, prev_code_r;
  logic             scan_done_r;
  logic [3:0]       db_cnt_r, db_next_s;
  logic             same_s, stable_s;
  state_t           state_r;
  logic [1:0]       gap_cnt_r;
  logic [3:0]       pend_r;
  logic             gap_none_r;

  assign tc_s = (div_r == DIV_LAST);

  // Two-flop synchroniser for the asynchronous row returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
    end
  end

  // Column divider: sample the active column at terminal count, then rotate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r     <= '0;
      col_idx_r <= 2'd0;
      col       <= 4'b1110;
      hits_r    <= 16'h0000;
    end else if (tc_s) begin
      div_r <= '0;
      for (int r = 0; r < 4; r++) begin
        hits_r[{2'(r), col_idx_r}] <= ~row_sync_r[r];
      end
      col_idx_r <= col_idx_r + 2'd1;
      col       <= {col[2:0], col[3]};
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Full-scan hit map with column 3 taken live, plus hit count and code.
  always_comb begin
    scan_hits_s = hits_r;
    hit_cnt_s   = 5'd0;
    hit_code_s  = 4'd0;
    for (int r = 0; r < 4; r++) begin
      scan_hits_s[{2'(r), 2'd3}] = ~row_sync_r[r];
    end
    for (int i = 0; i < 16; i++) begin
      hit_cnt_s = hit_cnt_s + {4'd0, scan_hits_s[i]};
      if (scan_hits_s[i]) begin
        hit_code_s = 4'(i);
      end else begin
        hit_code_s = hit_code_s;
      end
    end
  end

  // Classify the scan on the column-3 sample edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_done_r <= 1'b0;
      res_type_r  <= RES_NONE;
      res_code_r  <= 4'd0;
    end else if (tc_s && (col_idx_r == 2'd3)) begin
      scan_done_r <= 1'b1;
      res_type_r  <= (hit_cnt_s == 5'd0) ? RES_NONE : (hit_cnt_s == 5'd1) ? RES_KEY : RES_MULTI;
      res_code_r  <= (hit_cnt_s == 5'd1) ? hit_code_s : 4'd0;
    end else begin
      scan_done_r <= 1'b0;
    end
  end

  always_comb begin
    same_s = (res_type_r == prev_type_r) && (res_code_r == prev_code_r);
    if (same_s) begin
      db_next_s = (db_cnt_r == DB_MAX) ? DB_MAX : db_cnt_r + 4'd1;
    end else begin
      db_next_s = 4'd1;
    end
    stable_s = scan_done_r && (db_next_s == DB_MAX);
  end

  // Debounce history, updated once per completed scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_type_r <= RES_NONE;
      prev_code_r <= 4'd0;
      db_cnt_r    <= 4'd0;
    end else if (scan_done_r) begin
      prev_type_r <= res_type_r;
      prev_code_r <= res_code_r;
      db_cnt_r    <= db_next_s;
    end else begin
      db_cnt_r <= db_cnt_r;
    end
  end

  // Key-strobe FSM; a stable MULTI never moves it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      bcds       <= 4'hF;
      nkpls      <= 1'b1;
      koff       <= 1'b1;
      clr        <= 1'b0;
      gap_cnt_r  <= 2'd0;
      pend_r     <= 4'd0;
      gap_none_r <= 1'b0;
    end else begin
      clr <= 1'b0;
      case (state_r)
        IDLE: begin
          if (stable_s && (res_type_r == RES_KEY)) begin
            state_r <= PRESSED;
            bcds    <= res_code_r;
            nkpls   <= 1'b0;
            koff    <= 1'b0;
            clr     <= (res_code_r == CLR_CODE);
          end else begin
            state_r <= IDLE;
          end
        end
        PRESSED: begin
          if (stable_s && (res_type_r == RES_NONE)) begin
            state_r <= IDLE;
            nkpls   <= 1'b1;
            koff    <= 1'b1;
          end else if (stable_s && (res_type_r == RES_KEY) && (res_code_r != bcds)) begin
            state_r    <= GAP;
            nkpls      <= 1'b1;
            pend_r     <= res_code_r;
            gap_cnt_r  <= 2'd0;
            gap_none_r <= 1'b0;
          end else begin
            state_r <= PRESSED;
          end
        end
        GAP: begin
          if (gap_cnt_r == 2'd3) begin
            if (gap_none_r || (stable_s && (res_type_r == RES_NONE))) begin
              state_r <= IDLE;
              koff    <= 1'b1;
            end else begin
              state_r <= PRESSED;
              bcds    <= pend_r;
              nkpls   <= 1'b0;
              clr     <= (pend_r == CLR_CODE);
            end
          end else begin
            gap_cnt_r  <= gap_cnt_r + 2'd1;
            gap_none_r <= gap_none_r || (stable_s && (res_type_r == RES_NONE));
          end
        end
        default: begin
          state_r <= IDLE;
          nkpls   <= 1'b1;
          koff    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl: a vector table of held key sets plus
// hand sequences for reset, bounce, clear, roll-over and reset mid-press.
module tb_key_scan_ctrl;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;
  localparam int LAT  = (DB + 1) * 4 * SD + 3;

  logic       rst;
  logic       clk;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] bcds;
  logic       nkpls;
  logic       koff;
  logic       clr;
  logic [15:0] keys;

  int n_checks = 0;
  int n_fail   = 0;
  int falls    = 0;
  int clr_cyc  = 0;
  logic nkpls_q = 1'b1;

  key_scan_ctrl #(.SCAN_DIV(SD), .DB_SCANS(DB), .CLR_CODE(4'hE)) dut (
    .rst(rst), .clk(clk), .row(row), .col(col),
    .bcds(bcds), .nkpls(nkpls), .koff(koff), .clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a held key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (nkpls_q && !nkpls) falls <= falls + 1;
    if (clr) clr_cyc <= clr_cyc + 1;
    nkpls_q <= nkpls;
  end

  typedef struct {
    logic [15:0] keys;
    int          scans;
    logic        nkpls;
    logic        koff;
    logic [3:0]  bcds;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_scans(input int n);
    repeat (n * SCAN) @(posedge clk);
    #1;
  endtask

  task automatic wait_nkpls(input logic lvl, input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < budget && !ok) begin
      @(posedge clk); #1;
      cyc++;
      if (nkpls === lvl) ok = 1'b1;
    end
  endtask

  initial begin
    int f0, cyc, hi;
    bit ok, koff_ok;
    logic [3:0] exp_col;

    vecs[0]  = '{16'h0000, 6, 1'b1, 1'b1, 4'hF};
    vecs[1]  = '{16'h0040, 6, 1'b0, 1'b0, 4'h6};
    vecs[2]  = '{16'h0000, 6, 1'b1, 1'b1, 4'h6};
    vecs[3]  = '{16'h0200, 6, 1'b0, 1'b0, 4'h9};
    vecs[4]  = '{16'h0600, 6, 1'b0, 1'b0, 4'h9};
    vecs[5]  = '{16'h0000, 6, 1'b1, 1'b1, 4'h9};
    vecs[6]  = '{16'h0006, 6, 1'b1, 1'b1, 4'h9};
    vecs[7]  = '{16'h0000, 6, 1'b1, 1'b1, 4'h9};
    vecs[8]  = '{16'h8000, 6, 1'b0, 1'b0, 4'hF};
    vecs[9]  = '{16'h0000, 6, 1'b1, 1'b1, 4'hF};
    vecs[10] = '{16'h0001, 6, 1'b0, 1'b0, 4'h0};
    vecs[11] = '{16'h0000, 6, 1'b1, 1'b1, 4'h0};

    keys = 16'h0000;
    rst  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state and column stepping with no keys
    exp_col = 4'b1110;
    for (int s = 0; s < 5; s++) begin
      check("reset_col", {12'd0, col}, {12'd0, exp_col});
      check("reset_outs", {9'd0, bcds, nkpls, koff, clr}, {9'd0, 4'hF, 1'b1, 1'b1, 1'b0});
      repeat (SD) @(posedge clk);
      #1;
      exp_col = {exp_col[2:0], exp_col[3]};
    end

    // Table of held key sets
    for (int i = 0; i < 12; i++) begin
      keys = vecs[i].keys;
      run_scans(vecs[i].scans);
      check($sformatf("vec%0d_nkpls", i), {15'd0, nkpls}, {15'd0, vecs[i].nkpls});
      check($sformatf("vec%0d_koff", i),  {15'd0, koff},  {15'd0, vecs[i].koff});
      check($sformatf("vec%0d_bcds", i),  {12'd0, bcds},  {12'd0, vecs[i].bcds});
    end

    // Bounce: key 3 on/off per scan twice, then held
    f0 = falls;
    for (int t = 0; t < 2; t++) begin
      keys = 16'h0008; repeat (SCAN) @(posedge clk);
      keys = 16'h0000; repeat (SCAN) @(posedge clk);
    end
    keys = 16'h0008;
    run_scans(6);
    check("bounce_falls", 16'(falls - f0), 16'd1);
    check("bounce_bcds", {12'd0, bcds}, 16'h0003);
    keys = 16'h0000;
    run_scans(6);

    // Clear key: clr coincident with nkpls falling, one cycle wide
    keys = 16'h4000;
    wait_nkpls(1'b0, LAT, cyc, ok);
    check("clr_press_seen", {15'd0, ok}, 16'd1);
    check("clr_on_fall", {15'd0, clr}, 16'd1);
    check("clr_bcds", {12'd0, bcds}, 16'h000E);
    @(posedge clk); #1;
    check("clr_one_cycle", {15'd0, clr}, 16'd0);
    keys = 16'h0000;
    run_scans(6);

    // Roll-over 3 -> 5: nkpls high exactly 4 cycles with koff low
    keys = 16'h0008;
    run_scans(6);
    check("roll_first", {11'd0, nkpls, bcds}, {11'd0, 1'b0, 4'h3});
    keys = 16'h0020;
    wait_nkpls(1'b1, LAT, cyc, ok);
    check("roll_rise_seen", {15'd0, ok}, 16'd1);
    check("roll_bcds_held", {12'd0, bcds}, 16'h0003);
    hi = 1;
    koff_ok = (koff === 1'b0);
    while (nkpls === 1'b1 && hi < 20) begin
      @(posedge clk); #1;
      if (nkpls === 1'b1) hi++;
      if (koff !== 1'b0) koff_ok = 1'b0;
    end
    check("roll_gap_len", 16'(hi), 16'd4);
    check("roll_koff_low", {15'd0, koff_ok}, 16'd1);
    check("roll_second", {11'd0, nkpls, bcds}, {11'd0, 1'b0, 4'h5});
    keys = 16'h0000;
    run_scans(6);

    // Reset mid-press discards the key; re-acceptance needs a full debounce
    keys = 16'h0040;
    run_scans(6);
    check("rmp_pressed", {15'd0, nkpls}, 16'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rmp_async_outs", {9'd0, bcds, nkpls, koff, clr}, {9'd0, 4'hF, 1'b1, 1'b1, 1'b0});
    check("rmp_async_col", {12'd0, col}, 16'h000E);
    @(negedge clk);
    rst = 1'b1;
    f0 = falls;
    repeat (40) @(posedge clk);
    #1;
    check("rmp_no_early", {15'd0, nkpls}, 16'd1);
    wait_nkpls(1'b0, LAT - 40, cyc, ok);
    check("rmp_reaccept", {15'd0, ok}, 16'd1);
    check("rmp_bcds", {12'd0, bcds}, 16'h0006);
    keys = 16'h0000;
    run_scans(2);

    check("clr_total_cycles", 16'(clr_cyc), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
